// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: NS/EW/walk phase sequencer with emergency preemption
module intersection_phase_scheduler #(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR   = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        WALK = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK_T - 1);

    state_t           r_state;
    state_t           w_next;
    state_t           w_dir_green;
    logic [CNT_W-1:0] r_timer;
    logic             r_ped_pend;
    logic             r_next_dir;
    logic             r_ped_ack;
    logic             w_ns_cross;
    logic             w_ew_cross;
    logic             w_walk_entry;

    assign w_ns_cross   = ew_car | r_ped_pend;
    assign w_ew_cross   = ns_car | r_ped_pend;
    assign w_dir_green  = r_next_dir ? EW_G : NS_G;
    assign w_walk_entry = (w_next == WALK) && (r_state != WALK);

    // next phase: greens yield to cross demand, emergencies preempt, walk is served from all-red
    always_comb begin
        w_next = r_state;
        case (r_state)
            NS_G: begin
                if (emg_req)
                    w_next = emg_dir ? NS_Y : NS_G;
                else if (w_ns_cross && ((r_timer >= L_GMIN && !ns_car) || r_timer >= L_GMAX))
                    w_next = NS_Y;
            end
            EW_G: begin
                if (emg_req)
                    w_next = emg_dir ? EW_G : EW_Y;
                else if (w_ew_cross && ((r_timer >= L_GMIN && !ew_car) || r_timer >= L_GMAX))
                    w_next = EW_Y;
            end
            NS_Y, EW_Y: w_next = (r_timer == L_YEL) ? AR : r_state;
            AR: begin
                if (r_timer == L_AR)
                    w_next = emg_req ? (emg_dir ? EW_G : NS_G) : r_ped_pend ? WALK : w_dir_green;
            end
            WALK: w_next = emg_req ? AR : (r_timer == L_WALK) ? w_dir_green : WALK;
            default: w_next = AR;
        endcase
    end

    // phase register and saturating phase timer that restarts on every phase change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= AR;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state) ? '0 : (&r_timer) ? r_timer : r_timer + CNT_W'(1);
        end
    end

    // pedestrian latch, direction to serve after all-red, and walk acknowledge pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ped_pend <= 1'b0;
            r_next_dir <= 1'b0;
            r_ped_ack  <= 1'b0;
        end else begin
            r_ped_pend <= w_walk_entry ? 1'b0 : (ped_req && r_state != WALK) ? 1'b1 : r_ped_pend;
            r_next_dir <= (w_next == NS_Y && r_state != NS_Y) ? 1'b1 :
                          (w_next == EW_Y && r_state != EW_Y) ? 1'b0 : r_next_dir;
            r_ped_ack  <= w_walk_entry;
        end
    end

    // lamp decode from the registered phase
    always_comb begin
        ns_light = (r_state == NS_G) ? 3'b001 : (r_state == NS_Y) ? 3'b010 : 3'b100;
        ew_light = (r_state == EW_G) ? 3'b001 : (r_state == EW_Y) ? 3'b010 : 3'b100;
        walk     = (r_state == WALK);
        ped_ack  = r_ped_ack;
        phase    = r_state;
    end
endmodule
